// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR burst generator: FSM encoding and the raw Fibonacci step.
// lfsr_step has no zero check; callers decide how to escape the all-zero state.
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    localparam int          DEF_WIDTH = 8;
    localparam logic [7:0]  DEF_TAPS  = 8'h1D;
    localparam int          MAX_W     = 64;

    // Operands are zero-extended to MAX_W; feedback lands at bit width-1, so upper bits stay zero.
    function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] state,
                                                   input logic [MAX_W-1:0] taps,
                                                   input int               width);
        logic fb;
        fb = ^(state & taps);
        return (state >> 1) | (MAX_W'(fb) << (width - 1));
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with seed load, single-step advance and zero substitution.
// Load/advance take effect on the next edge; lockup pulses the cycle after a zero is replaced.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] RESEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [WIDTH-1:0] seed,
    input  logic             adv_en,
    output logic [WIDTH-1:0] state,
    output logic             lockup
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             lockup_q, lockup_d;
    logic [MAX_W-1:0] step_full;
    logic [WIDTH-1:0] cand;
    logic             cand_zero;

    assign step_full = lfsr_step(MAX_W'(state_q), MAX_W'(TAPS), WIDTH);

    // Load wins over advance; the top only ever asserts one of them at a time anyway.
    always_comb begin
        state_d   = state_q;
        lockup_d  = 1'b0;
        cand      = load_en ? seed : step_full[WIDTH-1:0];
        cand_zero = load_en ? (seed == '0) : (step_full == '0);
        if (load_en || adv_en) begin
            if (cand_zero) begin
                state_d  = RESEED;
                lockup_d = 1'b1;
            end else begin
                state_d  = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RESEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end

    assign state  = state_q;
    assign lockup = lockup_q;

endmodule

// File: rtl/lfsr_burst_gen.sv
// Burst generator: emits `count` LFSR words over valid/ready, first word one cycle after start.
// out_ready low holds rand_num and the counter; done pulses the cycle after the last acceptance.
module lfsr_burst_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] RESEED = WIDTH'(1),
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rand_num,
    output logic             busy,
    output logic             done,
    output logic             lockup
);

    fsm_e             fsm_q;
    logic [CNT_W-1:0] remaining_q;
    logic             busy_q;
    logic             done_q;
    logic             load_en;
    logic             adv_en;

    assign load_en = load && (fsm_q == IDLE);
    assign adv_en  = busy_q && out_ready;

    lfsr_core #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .RESEED (RESEED)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .load_en (load_en),
        .seed    (seed),
        .adv_en  (adv_en),
        .state   (rand_num),
        .lockup  (lockup)
    );

    // Burst ends on the acceptance that sees remaining == 1, so the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start && (count != '0)) begin
                        fsm_q       <= RUN;
                        remaining_q <= count;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            fsm_q  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    fsm_q  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_lfsr_burst_gen.sv
// Scoreboard bench for lfsr_burst_gen: an 8-bit instance for the main scenarios and a 4-bit
// instance for the full-period check.
module tb_lfsr_burst_gen;

    logic        clk;
    logic        rst;
    logic        load, start, out_ready;
    logic [7:0]  seed;
    logic [15:0] count;
    logic        out_valid, busy, done, lockup;
    logic [7:0]  rand_num;

    logic        load4, start4, out_ready4;
    logic [3:0]  seed4;
    logic [15:0] count4;
    logic        out_valid4, busy4, done4, lockup4;
    logic [3:0]  rand_num4;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [3:0] exp4_q[$];

    lfsr_burst_gen dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .seed      (seed),
        .start     (start),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rand_num  (rand_num),
        .busy      (busy),
        .done      (done),
        .lockup    (lockup)
    );

    lfsr_burst_gen #(
        .WIDTH  (4),
        .TAPS   (4'h3),
        .RESEED (4'h1),
        .CNT_W  (16)
    ) dut4 (
        .clk       (clk),
        .rst       (rst),
        .load      (load4),
        .seed      (seed4),
        .start     (start4),
        .count     (count4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .rand_num  (rand_num4),
        .busy      (busy4),
        .done      (done4),
        .lockup    (lockup4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference step: shift right, parity of tapped bits into the MSB, zero replaced by 1.
    function automatic logic [7:0] m_step(input logic [7:0] s, input logic [7:0] taps, input int w);
        logic       fb;
        logic [7:0] r;
        fb = 1'b0;
        for (int i = 0; i < w; i++)
            if (taps[i]) fb = fb ^ s[i];
        r = s >> 1;
        r[w-1] = fb;
        if (r == 8'h00) r = 8'h01;
        return r;
    endfunction

    // Drive load+start together for one cycle and queue the expected burst; m_next = state after burst.
    task automatic kick(input logic [7:0] sd, input int n, output logic [7:0] m_next);
        logic [7:0] m;
        m = (sd == 8'h00) ? 8'h01 : sd;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m);
            m = m_step(m, 8'h1D, 8);
        end
        m_next = m;
        load  = 1'b1;
        seed  = sd;
        start = 1'b1;
        count = 16'(n);
        @(posedge clk); #1;
        load  = 1'b0;
        start = 1'b0;
    endtask

    // Consume the queued burst; optionally stall stall_len cycles once stall_after words are taken.
    task automatic drain(input int stall_after, input int stall_len, output int dones);
        int acc    = 0;
        int stalls = 0;
        int cyc    = 0;
        dones = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            if (done) dones++;
            if (acc == stall_after && stalls < stall_len) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_valid got %b exp 1 (word %0d)", out_valid, acc);
            end
            checks++;
            if (rand_num !== exp_q[0]) begin
                errors++;
                $display("FAIL drain_word got %h exp %h (word %0d)", rand_num, exp_q[0], acc);
            end
            if (out_ready) begin
                void'(exp_q.pop_front());
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL drain_timeout got %0d left exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_done_tail(input string name, input logic [7:0] m_next, input int dones);
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL %s_early_done got %0d exp 0", name, dones);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got done=%b busy=%b vld=%b exp 1 0 0", name, done, busy, out_valid);
        end
        checks++;
        if (rand_num !== m_next) begin
            errors++;
            $display("FAIL %s_final got %h exp %h", name, rand_num, m_next);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || rand_num !== m_next) begin
            errors++;
            $display("FAIL %s_after got done=%b rand=%h exp 0 %h", name, done, rand_num, m_next);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load = 0; start = 0; seed = 0; count = 0; out_ready = 0;
        load4 = 0; start4 = 0; seed4 = 0; count4 = 0; out_ready4 = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rand_num !== 8'h01 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got rand=%h vld=%b exp 01 0", rand_num, out_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rand_num !== 8'h01 || out_valid !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || lockup !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle got rand=%h vld=%b busy=%b done=%b lk=%b exp 01 0 0 0 0",
                         rand_num, out_valid, busy, done, lockup);
            end
        end
    endtask

    task automatic test_load_start_burst();
        logic [7:0] m_next;
        int dones;
        out_ready = 1'b1;
        kick(8'h01, 5, m_next);
        drain(-1, 0, dones);
        check_done_tail("burst5", m_next, dones);
        checks++;
        if (m_next !== 8'h88) begin
            errors++;
            $display("FAIL burst5_model got %h exp 88", m_next);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] m_next;
        int dones;
        kick(8'h01, 3, m_next);
        drain(1, 3, dones);
        check_done_tail("stall", m_next, dones);
    endtask

    task automatic test_zero_seed();
        load = 1'b1;
        seed = 8'h00;
        @(posedge clk); #1;
        load = 1'b0;
        checks++;
        if (rand_num !== 8'h01 || lockup !== 1'b1) begin
            errors++;
            $display("FAIL zero_seed got rand=%h lk=%b exp 01 1", rand_num, lockup);
        end
        @(posedge clk); #1;
        checks++;
        if (lockup !== 1'b0) begin
            errors++;
            $display("FAIL zero_seed_pulse got lk=%b exp 0", lockup);
        end
        start = 1'b1;
        count = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rand_num !== 8'h01) begin
                errors++;
                $display("FAIL count_zero got busy=%b done=%b vld=%b rand=%h exp 0 0 0 01",
                         busy, done, out_valid, rand_num);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_ignored_and_abort();
        logic [7:0] m_next;
        int acc = 0;
        int cyc = 0;
        kick(8'h01, 10, m_next);
        while (acc < 6 && cyc < 50) begin
            out_ready = 1'b1;
            if (acc >= 3) begin
                load = 1'b1;
                seed = 8'hAA;
            end
            checks++;
            if (out_valid !== 1'b1 || rand_num !== exp_q[0]) begin
                errors++;
                $display("FAIL run_load got vld=%b rand=%h exp 1 %h", out_valid, rand_num, exp_q[0]);
            end
            void'(exp_q.pop_front());
            acc++;
            @(posedge clk); #1;
            cyc++;
        end
        load = 1'b0;
        rst  = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || rand_num !== 8'h01 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort got vld=%b rand=%h busy=%b exp 0 01 0", out_valid, rand_num, busy);
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || rand_num !== 8'h01) begin
                errors++;
                $display("FAIL abort_idle got done=%b busy=%b rand=%h exp 0 0 01", done, busy, rand_num);
            end
        end
    endtask

    task automatic test_width4_period();
        logic [7:0] m;
        logic [15:0] seen;
        int lk  = 0;
        int cyc = 0;
        seen = '0;
        m = 8'h01;
        for (int i = 0; i < 15; i++) begin
            exp4_q.push_back(m[3:0]);
            m = m_step(m, 8'h03, 4);
        end
        load4 = 1'b1; seed4 = 4'h1; start4 = 1'b1; count4 = 16'd15; out_ready4 = 1'b1;
        @(posedge clk); #1;
        load4 = 1'b0; start4 = 1'b0;
        while (exp4_q.size() != 0 && cyc < 100) begin
            if (lockup4) lk++;
            checks++;
            if (out_valid4 !== 1'b1 || rand_num4 !== exp4_q[0]) begin
                errors++;
                $display("FAIL w4_word got vld=%b rand=%h exp 1 %h", out_valid4, rand_num4, exp4_q[0]);
            end
            checks++;
            if (seen[rand_num4] || rand_num4 == 4'h0) begin
                errors++;
                $display("FAIL w4_distinct got %h exp new non-zero", rand_num4);
            end
            seen[rand_num4] = 1'b1;
            void'(exp4_q.pop_front());
            @(posedge clk); #1;
            cyc++;
        end
        if (lockup4) lk++;
        checks++;
        if (cyc >= 100) begin
            errors++;
            $display("FAIL w4_timeout got %0d left exp 0", exp4_q.size());
        end
        checks++;
        if (rand_num4 !== 4'h1 || done4 !== 1'b1) begin
            errors++;
            $display("FAIL w4_wrap got rand=%h done=%b exp 1 1", rand_num4, done4);
        end
        checks++;
        if (lk !== 0) begin
            errors++;
            $display("FAIL w4_lockup got %0d exp 0", lk);
        end
    endtask

    initial begin
        test_reset();
        test_load_start_burst();
        test_backpressure();
        test_zero_seed();
        test_load_ignored_and_abort();
        test_width4_period();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
